fp_issue_queue: RTL and testbench

FP_ISSUE_QUEUE -- requirements
Module: fp_issue_queue

---
 rtl/fp_issue_queue.sv | 136 +++++++++++++
 tb/tb_fp_issue_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_queue.sv
// Operand queue in front of a single-precision adder: buffers requests, issues one at a time,
// holds each result until taken downstream. Optional WAIT watchdog under `FP_ISSUE_TIMEOUT_EN.
module fp_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic        add_start,
    output logic        mode,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic [31:0] add_result,
    input  logic        add_done,
    input  logic        add_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_timeout,
    output logic [1:0]  o_dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid is never withdrawn by this block until its transfer completes.
    state_t          r_state, w_next;
    logic            r_mode_q [DEPTH];
    logic [31:0]     r_op1_q  [DEPTH];
    logic [31:0]     r_op2_q  [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_mode;
    logic [31:0]     r_op1, r_op2, r_result;
    logic            r_overflow, r_timeout;
    logic            w_push, w_pop, w_expire;

    assign in_ready     = (r_count < CW'(DEPTH));
    assign w_push       = in_valid & in_ready;
    assign w_pop        = (r_state == S_ISSUE);
    assign add_start    = (r_state == S_ISSUE);
    assign mode         = r_mode;
    assign op1          = r_op1;
    assign op2          = r_op2;
    assign out_valid    = (r_state == S_HOLD);
    assign out_result   = r_result;
    assign out_overflow = r_overflow;
    assign out_timeout  = r_timeout;
    assign o_dbg_state  = r_state;

`ifdef FP_ISSUE_TIMEOUT_EN
    logic [7:0] r_wd;

    // Expiry on the edge that ends the 64th WAIT cycle; a coincident add_done wins.
    assign w_expire = (r_state == S_WAIT) && (r_wd == 8'd63) && !add_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd <= 8'd0;
        end else if (r_state == S_ISSUE) begin
            r_wd <= 8'd0;
        end else if (r_state == S_WAIT) begin
            r_wd <= r_wd + 8'd1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (add_done || w_expire) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mode_q[r_wr_ptr] <= in_mode;
            r_op1_q[r_wr_ptr]  <= in_op1;
            r_op2_q[r_wr_ptr]  <= in_op2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_mode     <= 1'b0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_result   <= 32'd0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Head is latched when ISSUE is entered and held through WAIT.
            if (r_state == S_IDLE && w_next == S_ISSUE) begin
                r_mode <= r_mode_q[r_rd_ptr];
                r_op1  <= r_op1_q[r_rd_ptr];
                r_op2  <= r_op2_q[r_rd_ptr];
            end
            if (r_state == S_WAIT && w_next == S_HOLD) begin
                if (add_done) begin
                    r_result   <= add_result;
                    r_overflow <= add_overflow;
                    r_timeout  <= 1'b0;
                end else begin
                    r_result   <= 32'h7FC0_0000;
                    r_overflow <= 1'b0;
                    r_timeout  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed bench for fp_issue_queue with a table-driven adder model and an ordered result queue.
module tb_fp_issue_queue;
    logic        clk, rst;
    logic        in_valid, in_ready, in_mode;
    logic [31:0] in_op1, in_op2;
    logic        add_start, mode;
    logic [31:0] op1, op2, add_result;
    logic        add_done, add_overflow;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_overflow, out_timeout;
    logic [1:0]  o_dbg_state;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int m_lat = 3;
    logic m_en = 1'b1;
    logic [31:0] exp_q[$];

    fp_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_op1(in_op1), .in_op2(in_op2),
        .add_start(add_start), .mode(mode), .op1(op1), .op2(op2),
        .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .out_timeout(out_timeout),
        .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (add_start === 1'b1) pulses++;

    // Known single-precision sums; {overflow, result}.
    function automatic logic [32:0] fake_fadd(input logic m, input logic [31:0] a, input logic [31:0] b);
        if (!m && a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
        if ( m && a == 32'h40400000 && b == 32'h3F800000) return {1'b0, 32'h40000000};
        if (!m && a == 32'h40000000 && b == 32'h40000000) return {1'b0, 32'h40800000};
        if (!m && a == 32'h40800000 && b == 32'h3F800000) return {1'b0, 32'h40A00000};
        if (!m && a == 32'h40A00000 && b == 32'h3F800000) return {1'b0, 32'h40C00000};
        if (!m && a == 32'h7F800000 && b == 32'h78000000) return {1'b1, 32'h7F800000};
        return {1'b0, 32'hDEADBEEF};
    endfunction

    // Adder model: answers m_lat edges after it sees add_start, using the operands then on the bus.
    initial begin : adder_model
        logic [32:0] r;
        add_done = 1'b0; add_result = 32'd0; add_overflow = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (add_start === 1'b1 && m_en) begin
                repeat (m_lat) @(posedge clk);
                #1;
                r = fake_fadd(mode, op1, op2);
                add_done = 1'b1; add_result = r[31:0]; add_overflow = r[32];
                @(posedge clk); #1;
                add_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1; in_mode = m; in_op1 = a; in_op2 = b;
        while (in_ready !== 1'b1 && n < 50) begin step(); n++; end
        if (n >= 50) check("push_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] v [5];
        logic        vm [5];
        int p0;
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_op1 = 32'd0; in_op2 = 32'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_add_start", {31'd0, add_start}, 32'd0);
        check("rst_mode", {31'd0, mode}, 32'd0);
        check("rst_op1", op1, 32'd0);
        check("rst_op2", op2, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_overflow", {31'd0, out_overflow}, 32'd0);
        check("rst_out_timeout", {31'd0, out_timeout}, 32'd0);

        // Single op: 1.0 + 2.0
        m_lat = 3;
        in_valid = 1'b1; in_mode = 1'b0; in_op1 = 32'h3F800000; in_op2 = 32'h40000000;
        step();
        in_valid = 1'b0;
        check("single_no_start_yet", {31'd0, add_start}, 32'd0);
        step();
        check("single_start", {31'd0, add_start}, 32'd1);
        check("single_op1", op1, 32'h3F800000);
        check("single_op2", op2, 32'h40000000);
        step();
        check("single_start_width", {31'd0, add_start}, 32'd0);
        check("single_wait_state", {30'd0, o_dbg_state}, 32'd2);
        check("single_op1_hold", op1, 32'h3F800000);
        wait_valid("single_valid");
        check("single_result", out_result, 32'h40400000);
        check("single_ovf", {31'd0, out_overflow}, 32'd0);
        check("single_tmo", {31'd0, out_timeout}, 32'd0);
        release_result();
        check("single_released", {31'd0, out_valid}, 32'd0);

        // Fill: five back-to-back pushes with out_ready low
        vm = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        v  = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h40A00000};
        exp_q.push_back(32'h40400000); exp_q.push_back(32'h40000000); exp_q.push_back(32'h40800000);
        exp_q.push_back(32'h40A00000); exp_q.push_back(32'h40C00000);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_mode = vm[k]; in_op1 = v[k];
            in_op2 = (k == 0) ? 32'h40000000 : (k == 2) ? 32'h40000000 : 32'h3F800000;
            check($sformatf("fill_ready_%0d", k), {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        check("fill_full", {31'd0, in_ready}, 32'd0);
        step();
        check("fill_still_full", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            wait_valid($sformatf("fill_valid_%0d", k));
            check($sformatf("fill_order_%0d", k), out_result, exp_q.pop_front());
            release_result();
        end
        check("fill_drained_ready", {31'd0, in_ready}, 32'd1);

        // Overflow pass-through
        push(1'b0, 32'h7F800000, 32'h78000000);
        wait_valid("ovf_valid");
        check("ovf_result", out_result, 32'h7F800000);
        check("ovf_flag", {31'd0, out_overflow}, 32'd1);
        release_result();

        // Backpressure: second op queued behind a held result
        push(1'b0, 32'h3F800000, 32'h40000000);
        push(1'b0, 32'h40800000, 32'h3F800000);
        wait_valid("bp_valid");
        p0 = pulses;
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_result", out_result, 32'h40400000);
            check("bp_no_restart", pulses, p0);
        end
        release_result();
        wait_valid("bp_valid2");
        check("bp_result2", out_result, 32'h40A00000);
        check("bp_one_more_start", pulses, p0 + 1);
        release_result();

        // Reset mid-WAIT; stale add_done arrives afterwards; rst beats in_valid
        m_lat = 4;
        push(1'b0, 32'h3F800000, 32'h40000000);
        step();
        check("rw_start", {31'd0, add_start}, 32'd1);
        step();
        check("rw_in_wait", {30'd0, o_dbg_state}, 32'd2);
        rst = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rw_idle", {30'd0, o_dbg_state}, 32'd0);
        check("rw_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rw_no_valid", {31'd0, out_valid}, 32'd0);
            check("rw_stay_idle", {30'd0, o_dbg_state}, 32'd0);
        end
        check("rw_ready_after", {31'd0, in_ready}, 32'd1);
        check("rw_result_clear", out_result, 32'd0);

        // Silent adder
        m_en = 1'b0;
        push(1'b0, 32'h3F800000, 32'h40000000);
        step();
        check("wd_start", {31'd0, add_start}, 32'd1);
`ifdef FP_ISSUE_TIMEOUT_EN
        repeat (64) step();
        check("wd_not_yet", {31'd0, out_valid}, 32'd0);
        step();
        check("wd_valid", {31'd0, out_valid}, 32'd1);
        check("wd_result", out_result, 32'h7FC00000);
        check("wd_tmo", {31'd0, out_timeout}, 32'd1);
        check("wd_ovf", {31'd0, out_overflow}, 32'd0);
        release_result();
`else
        repeat (70) step();
        check("wait_forever_valid", {31'd0, out_valid}, 32'd0);
        check("wait_forever_state", {30'd0, o_dbg_state}, 32'd2);
        check("wait_forever_tmo", {31'd0, out_timeout}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        m_en = 1'b1;
        check("end_idle", {30'd0, o_dbg_state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
